// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes, status flags
// and an optional multi-cycle shift-add multiply enabled by ALU_PIPE_MUL_EN.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   in_valid/in_ready         input handshake (A, B, op)
//   A, B [WIDTH-1:0], op [2:0] operands and opcode
//   out_valid/out_ready       output handshake
//   alu_out, alu_out_hi       result low half, product high half
//   flag_c/z/n/v              carry/borrow, zero, negative, signed overflow
//
// Macro ALU_PIPE_MUL_EN: when defined, op 111 is an unsigned WIDTH-step
// shift-add multiply. When undefined, op 111 completes in one cycle with 0.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    logic             accept;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;

    // Single-cycle datapath; the extra top bit carries out / borrows.
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            3'b001: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                         (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            3'b010: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                         (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            3'b011:  sc_res = A & B;
            3'b100:  sc_res = A | B;
            3'b101:  sc_res = ~A;
            3'b110:  sc_res = ~B;
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   step_sum;

    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);

    // Right-shifting multiplier: {acc, mplr} holds the partial product,
    // the multiplier bits drain out of the bottom of mplr.
    assign step_sum = {1'b0, acc_q} +
                      (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`else
    assign in_ready = !valid_q || out_ready;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        hi_d    = hi_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
`ifdef ALU_PIPE_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (accept && op == 3'b111) begin
                    state_d = MUL;
                    mcand_d = A;
                    mplr_d  = B;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end else if (accept) begin
                    valid_d = 1'b1;
                    res_d   = sc_res;
                    hi_d    = '0;
                    c_d     = sc_c;
                    v_d     = sc_v;
                    z_d     = (sc_res == '0);
                    n_d     = sc_res[WIDTH-1];
                end else if (out_ready) begin
                    valid_d = 1'b0;
                end
            end
            MUL: begin
                acc_d  = step_sum[WIDTH:1];
                mplr_d = {step_sum[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    res_d   = mplr_d;
                    hi_d    = acc_d;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    z_d     = (mplr_d == '0);
                    n_d     = mplr_d[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (accept) begin
            valid_d = 1'b1;
            res_d   = sc_res;
            hi_d    = '0;
            c_d     = sc_c;
            v_d     = sc_v;
            z_d     = (sc_res == '0);
            n_d     = sc_res[WIDTH-1];
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
        end
    end

`ifdef ALU_PIPE_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
        end
    end
`endif

    assign out_valid  = valid_q;
    assign alu_out    = res_q;
    assign alu_out_hi = hi_q;
    assign flag_c     = c_q;
    assign flag_z     = z_q;
    assign flag_n     = n_q;
    assign flag_v     = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (WIDTH=8), covering
// reset, arithmetic flags, streaming, backpressure, multiply and reset abort.
module tb_alu_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic [7:0] alu_out_hi;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;

    int n_chk;
    int n_pass;

    alu_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .alu_out_hi (alu_out_hi),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then drop in_valid.
    task automatic send(input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b);
        op       = o;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] lo,
                           input logic [7:0] hi, input logic [3:0] czn_v);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".lo"}, 32'(alu_out), 32'(lo));
        chk({tag, ".hi"}, 32'(alu_out_hi), 32'(hi));
        chk({tag, ".flags"}, 32'({flag_c, flag_z, flag_n, flag_v}),
            32'(czn_v));
    endtask

    logic [2:0] bb_op  [4];
    logic [7:0] bb_exp [4];

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        op        = '0;
        out_ready = 1'b1;
        bb_op     = '{3'b011, 3'b100, 3'b101, 3'b110};
        bb_exp    = '{8'h42, 8'hDB, 8'h3C, 8'hA5};

        step();
        step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.lo", 32'(alu_out), 32'd0);
        chk("rst.hi", 32'(alu_out_hi), 32'd0);
        chk("rst.flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        rst = 1'b0;
        step();
        chk("idle.in_ready", 32'(in_ready), 32'd1);

        // flags order: {c, z, n, v}
        send(3'b001, 8'hF0, 8'h20);
        chk_out("add", 8'h10, 8'h00, 4'b1000);

        send(3'b010, 8'h80, 8'h01);
        chk_out("sub_ovf", 8'h7F, 8'h00, 4'b0001);
        send(3'b010, 8'h03, 8'h05);
        chk_out("sub_brw", 8'hFE, 8'h00, 4'b1010);

        A = 8'hC3;
        B = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            op       = bb_op[i];
            in_valid = 1'b1;
            #1;
            chk($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("b2b%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d.lo", i), 32'(alu_out), 32'(bb_exp[i]));
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        send(3'b001, 8'h01, 8'h02);
        chk_out("bp.first", 8'h03, 8'h00, 4'b0000);
        op       = 3'b001;
        A        = 8'h7F;
        B        = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("bp%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d.lo", i), 32'(alu_out), 32'h03);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk_out("bp.next", 8'h80, 8'h00, 4'b0011);
        step();

        send(3'b111, 8'hFF, 8'hFF);
`ifdef ALU_PIPE_MUL_EN
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("mul%0d.in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("mul%0d.valid", i), 32'(out_valid), 32'd0);
            step();
        end
        chk("mul8.in_ready", 32'(in_ready), 32'd0);
        step();
        chk_out("mul", 8'h01, 8'hFE, 4'b0000);
`else
        chk_out("mul_off", 8'h00, 8'h00, 4'b0100);
`endif
        send(3'b000, 8'h55, 8'h55);
        chk_out("zero", 8'h00, 8'h00, 4'b0100);
        step();

        send(3'b111, 8'h12, 8'h34);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid.valid", 32'(out_valid), 32'd0);
        chk("rst_mid.lo", 32'(alu_out), 32'd0);
        chk("rst_mid.hi", 32'(alu_out_hi), 32'd0);
        chk("rst_mid.flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);
        send(3'b001, 8'h05, 8'h07);
        chk_out("post_rst.add", 8'h0C, 8'h00, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
